// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin arbiter sharing one single-port memory among
// NUM_REQ requesters. Ports: clk, rst_n (async, active low); requester side
// req/req_we/req_addr/req_wdata (+ req_lock with MEM_ARB_LOCK_EN) in, gnt/rvalid
// one-hot pulses and rdata out; memory side mem_we/mem_addr/mem_wdata out and
// mem_rdata in (registered in the target, 1-cycle latency).
// Optional feature macro: MEM_ARB_LOCK_EN (locked repeat grants, capped at MAX_LOCK).
module mem_rr_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int ADDR_W   = 4,
   parameter int DATA_W   = 8,
   parameter int MAX_LOCK = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
`ifdef MEM_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]        req_lock,
`endif
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        rvalid,
   output logic [DATA_W-1:0]         rdata,
   output logic                      mem_we,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic [DATA_W-1:0]         mem_rdata
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t             state, state_nx;
   logic [IW-1:0]      last_gnt;
   logic [IW-1:0]      pick;
   logic [IW-1:0]      idx;
   logic [IW-1:0]      win;
   logic               found;
   logic               any;
   logic               take;
   logic [NUM_REQ-1:0] win_oh;

   // scan starts one past the previous winner and wraps
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = IW'((int'(last_gnt) + k) % NUM_REQ);
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

`ifdef MEM_ARB_LOCK_EN
   localparam int LW = $clog2(MAX_LOCK + 1);

   logic [LW-1:0] lock_cnt;
   logic          lock_prev;
   logic          lock_hit;

   // a locked winner that still requests keeps the memory until the cap
   assign lock_hit = lock_prev && req[last_gnt] &&
                     (lock_cnt < LW'(MAX_LOCK));
   assign win = lock_hit ? last_gnt : pick;
   assign any = lock_hit || found;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_cnt  <= '0;
         lock_prev <= 1'b0;
      end else if (take) begin
         lock_prev <= req_lock[win];
         if (!req_lock[win])
            lock_cnt <= '0;
         else if (lock_hit)
            lock_cnt <= lock_cnt + LW'(1);
         else
            lock_cnt <= LW'(1);
      end
   end
`else
   assign win = pick;
   assign any = found;
`endif

   always_comb begin
      win_oh      = '0;
      win_oh[win] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      take     = 1'b0;
      unique case (state)
         IDLE: begin
            if (any) begin
               state_nx = ISSUE;
               take     = 1'b1;
            end
         end
         ISSUE:   state_nx = mem_we ? IDLE : WAIT;
         WAIT:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // last_gnt doubles as the current winner while in ISSUE/WAIT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt       <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         last_gnt  <= IW'(NUM_REQ - 1);
      end else if (take) begin
         gnt       <= win_oh;
         mem_we    <= req_we[win];
         mem_addr  <= req_addr[int'(win)*ADDR_W +: ADDR_W];
         mem_wdata <= req_wdata[int'(win)*DATA_W +: DATA_W];
         last_gnt  <= win;
      end else if (state == ISSUE) begin
         gnt    <= '0;
         mem_we <= 1'b0;
      end
   end

   always_comb begin
      rvalid = '0;
      if (state == WAIT)
         rvalid[last_gnt] = 1'b1;
   end

   assign rdata = mem_rdata;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter: scoreboard bench for mem_rr_arbiter.
// Expected grants/read data are queued at stimulus time, checked on output.
module tb_mem_rr_arbiter;
   localparam int N  = 4;
   localparam int AW = 4;
   localparam int DW = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req, req_we, gnt, rvalid;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
`ifdef MEM_ARB_LOCK_EN
   logic [N-1:0]    req_lock;
`endif
   logic [DW-1:0]   rdata, mem_rdata, mem_wdata;
   logic            mem_we;
   logic [AW-1:0]   mem_addr;

   mem_rr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req(req), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef MEM_ARB_LOCK_EN
      .req_lock(req_lock),
`endif
      .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
      .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          idx;
      logic        we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic        lock;
   } tx_t;

   typedef struct {
      int          idx;
      logic [DW-1:0] data;
      int          gc;
   } rd_t;

   tx_t pend[$];
   tx_t gq[$];
   rd_t rdq[$];
   int  gcyc[$];
   int  cyc = 0;
   int  checks = 0;
   int  errors = 0;
   int  req_cyc [N];

   logic [DW-1:0] mem     [16] = '{default: 8'h5A};
   logic [DW-1:0] ref_mem [16] = '{default: 8'h5A};

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic put(input int i, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic lk);
      tx_t t;
      t.idx = i; t.we = we; t.addr = a; t.wdata = d; t.lock = lk;
      pend.push_back(t);
      gq.push_back(t);
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((pend.size() + gq.size() + rdq.size()) != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_drain"}, 32'(n < 300), 1);
      pend.delete(); gq.delete(); rdq.delete();
      repeat (3) @(negedge clk);
   endtask

   // target memory: registered read, 1-cycle latency
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   always @(posedge clk) cyc <= cyc + 1;

   // requester model: present head of own queue, advance on gnt
   logic [N-1:0] seen, prev;
   int dj;
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < N; i++) begin
         if (rst_n && gnt[i]) begin
            for (int k = 0; k < pend.size(); k++) begin
               if (pend[k].idx == i) begin
                  pend.delete(k);
                  break;
               end
            end
         end
      end
      prev = req;
      seen = '0;
      req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
`ifdef MEM_ARB_LOCK_EN
      req_lock = '0;
`endif
      for (int k = 0; k < pend.size(); k++) begin
         dj = pend[k].idx;
         if (!seen[dj]) begin
            seen[dj] = 1'b1;
            req[dj] = 1'b1;
            req_we[dj] = pend[k].we;
            req_addr[dj*AW +: AW] = pend[k].addr;
            req_wdata[dj*DW +: DW] = pend[k].wdata;
`ifdef MEM_ARB_LOCK_EN
            req_lock[dj] = pend[k].lock;
`endif
         end
      end
      for (int i = 0; i < N; i++)
         if (req[i] && !prev[i]) req_cyc[i] = cyc;
   end

   // monitor: invariants, grant scoreboard, read-data scoreboard
   tx_t me;
   rd_t mr;
   always @(negedge clk) begin
      if (rst_n) begin
         chk("gnt_onehot", 32'($onehot0(gnt)), 1);
         chk("rvalid_onehot", 32'($onehot0(rvalid)), 1);
         chk("gnt_rvalid_excl", 32'(gnt != 0 && rvalid != 0), 0);
         if (gnt != 0) begin
            gcyc.push_back(cyc);
            if (gq.size() == 0)
               chk("gnt_unexpected", gnt, 0);
            else begin
               me = gq.pop_front();
               chk("gnt_idx", gnt, 32'(1) << me.idx);
               chk("mem_we", mem_we, me.we);
               chk("mem_addr", mem_addr, me.addr);
               if (me.we) begin
                  chk("mem_wdata", mem_wdata, me.wdata);
                  ref_mem[me.addr] = me.wdata;
               end else begin
                  mr.idx = me.idx;
                  mr.data = ref_mem[me.addr];
                  mr.gc = cyc;
                  rdq.push_back(mr);
               end
            end
         end else begin
            chk("we_idle", mem_we, 0);
         end
         if (rvalid != 0) begin
            if (rdq.size() == 0)
               chk("rvalid_unexpected", rvalid, 0);
            else begin
               mr = rdq.pop_front();
               chk("rvalid_idx", rvalid, 32'(1) << mr.idx);
               chk("rdata", rdata, mr.data);
               chk("rvalid_lat", cyc - mr.gc, 1);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit");
      $fatal(1);
   end

   int n;
   initial begin
      repeat (2) @(negedge clk);
      chk("rst_gnt", gnt, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // all four read back to back from reset: 0,1,2,3,0,1,2,3
      gcyc.delete();
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < N; i++)
            put(i, 1'b0, AW'(i + 4 * r), '0, 1'b0);
      drain("t2");
      chk("t2_count", gcyc.size(), 8);
      for (int k = 1; k < gcyc.size(); k++)
         chk("t2_gap", gcyc[k] - gcyc[k-1], 3);

      // write then read, requester 0
      gcyc.delete();
      put(0, 1'b1, 4'd3, 8'hA5, 1'b0);
      put(0, 1'b0, 4'd3, 8'h00, 1'b0);
      drain("t1");
      chk("t1_count", gcyc.size(), 2);
      if (gcyc.size() == 2) begin
         chk("t1_gnt_lat", gcyc[0] - req_cyc[0], 1);
         chk("t1_wr_next", gcyc[1] - gcyc[0], 2);
      end

      // pointer wraps past absent requester 3
      put(2, 1'b0, 4'd1, 8'h00, 1'b0);
      drain("t3a");
      put(1, 1'b0, 4'd2, 8'h00, 1'b0);
      put(2, 1'b0, 4'd3, 8'h00, 1'b0);
      drain("t3b");

      // reset in WAIT of a read by requester 1
      put(1, 1'b0, 4'd3, 8'h00, 1'b0);
      n = 0;
      while (!gnt[1] && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("t4_gnt1", gnt[1], 1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      pend.delete(); gq.delete(); rdq.delete();
      @(negedge clk);
      chk("t4_rvalid", rvalid, 0);
      chk("t4_gnt", gnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      put(0, 1'b0, 4'd3, 8'h00, 1'b0);
      put(2, 1'b0, 4'd3, 8'h00, 1'b0);
      drain("t4");

      // two writes to addr 7, then read back
      put(0, 1'b1, 4'd7, 8'h3C, 1'b0);
      put(1, 1'b1, 4'd7, 8'hC3, 1'b0);
      drain("t6a");
      put(1, 1'b0, 4'd7, 8'h00, 1'b0);
      drain("t6b");

`ifdef MEM_ARB_LOCK_EN
      // locked requester 2: four grants, then round robin resumes
      for (int k = 0; k < 4; k++)
         put(2, 1'b0, AW'(k), 8'h00, 1'b1);
      put(3, 1'b0, 4'd5, 8'h00, 1'b0);
      put(0, 1'b0, 4'd6, 8'h00, 1'b0);
      put(2, 1'b0, 4'd7, 8'h00, 1'b1);
      drain("t5");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
